// File: rtl/prog_seq_detector.sv
// prog_seq_detector
//   Mealy serial-pattern detector with a run-time programmable pattern and
//   length, an overlap/non-overlap mode and a saturating match counter.
//   Out of reset it behaves as an overlapping "1011" detector.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low
//   in           serial data bit
//   in_valid     qualifies in
//   cfg_we       load cfg_pattern / cfg_len / cfg_overlap this edge
//   cfg_pattern  pattern, bit [len-1] received first, bit [0] last
//   cfg_len      pattern length, 0 disables, clamped to MAX_LEN
//   cfg_overlap  1 = overlapping matches allowed
//   clr_count    synchronous clear of match_count
//   out          combinational match pulse
//   out_r        out delayed by one cycle
//   match_count  saturating number of matches
//   count_sat    match_count is all ones
module prog_seq_detector #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               out,
    output logic               out_r,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   fill_next;
    logic               fill_ok;

    // window is the candidate match: the newest MAX_LEN-1 history bits plus
    // the bit arriving now; mask keeps only the low len_r bits.
    always_comb begin
        window = {hist[MAX_LEN-2:0], in};
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_r));
        end
    end

    // fill >= len-1, written as fill+1 >= len to avoid underflow at len=0
    assign fill_ok = ({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, len_r};

    assign out = in_valid & ~cfg_we & (len_r != '0) & fill_ok &
                 (((window ^ pat_r) & mask) == '0);

    assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    // In non-overlap mode a match consumes its history bits.
    always_comb begin
        fill_next = fill;
        if (out && !ovl_r) begin
            fill_next = '0;
        end else if (fill != LEN_MAX) begin
            fill_next = fill + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist  <= '0;
            fill  <= '0;
            pat_r <= MAX_LEN'(11);
            len_r <= LEN_W'(4);
            ovl_r <= 1'b1;
        end else if (cfg_we) begin
            pat_r <= cfg_pattern;
            len_r <= len_clamped;
            ovl_r <= cfg_overlap;
            fill  <= '0;
        end else if (in_valid) begin
            hist  <= window;
            fill  <= fill_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_count <= '0;
            out_r       <= 1'b0;
        end else begin
            out_r <= out;
            if (clr_count) begin
                match_count <= '0;
            end else if (out && !count_sat) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

    assign count_sat = &match_count;

endmodule

// File: tb/tb_prog_seq_detector.sv
// tb_prog_seq_detector
//   Directed bench for prog_seq_detector. Two instances share all inputs:
//   dut (CNT_W=8) and dut_s (CNT_W=2, for counter saturation).
module tb_prog_seq_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               in;
    logic               in_valid;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clr_count;

    logic               out,   out_s;
    logic               out_r, out_r_s;
    logic [7:0]         match_count;
    logic [1:0]         match_count_s;
    logic               count_sat, count_sat_s;

    int total = 0;
    int bad   = 0;
    int exp_cnt   = 0;
    int exp_cnt_s = 0;

    prog_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .out(out), .out_r(out_r), .match_count(match_count),
        .count_sat(count_sat)
    );

    prog_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .out(out_s), .out_r(out_r_s), .match_count(match_count_s),
        .count_sat(count_sat_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_counts();
        chk("count",   32'(match_count),   32'(exp_cnt));
        chk("count_s", 32'(match_count_s), 32'(exp_cnt_s));
        chk("sat",     32'(count_sat),     32'(exp_cnt == 255));
        chk("sat_s",   32'(count_sat_s),   32'(exp_cnt_s == 3));
    endtask

    task automatic send_bit(input logic b, input logic exp_out, input logic clr);
        @(negedge clk);
        in = b; in_valid = 1'b1; cfg_we = 1'b0; clr_count = clr;
        #1;
        chk("out",   32'(out),   32'(exp_out));
        chk("out_s", 32'(out_s), 32'(exp_out));
        @(posedge clk);
        #1;
        if (clr) begin
            exp_cnt = 0; exp_cnt_s = 0;
        end else if (exp_out) begin
            if (exp_cnt   < 255) exp_cnt++;
            if (exp_cnt_s < 3)   exp_cnt_s++;
        end
        chk("out_r", 32'(out_r), 32'(exp_out));
        chk_counts();
        clr_count = 1'b0;
    endtask

    // bits sent MSB-first; exps is aligned bit-for-bit with bits
    task automatic send_seq(input logic [15:0] bits, input logic [15:0] exps, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            send_bit(bits[k], exps[k], 1'b0);
        end
    endtask

    task automatic idle(input logic clr);
        @(negedge clk);
        in = 1'($urandom); in_valid = 1'b0; cfg_we = 1'b0; clr_count = clr;
        #1;
        chk("idle_out", 32'(out), 32'(0));
        @(posedge clk);
        #1;
        if (clr) begin
            exp_cnt = 0; exp_cnt_s = 0;
        end
        chk_counts();
        clr_count = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        in = 1'b1; in_valid = 1'b1; clr_count = 1'b0;
        #1;
        chk("cfg_out",   32'(out),   32'(0));
        chk("cfg_out_s", 32'(out_s), 32'(0));
        @(posedge clk);
        #1;
        chk_counts();
        cfg_we = 1'b0; in_valid = 1'b0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        in = 1'b1; in_valid = 1'b1; cfg_we = 1'b0; clr_count = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        exp_cnt = 0; exp_cnt_s = 0;
        chk("rst_out",   32'(out),     32'(0));
        chk("rst_out_r", 32'(out_r),   32'(0));
        chk("rst_out_rs",32'(out_r_s), 32'(0));
        chk_counts();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; clr_count = 1'b0;
        #1;
        chk("reset_out_r", 32'(out_r), 32'(0));
        chk_counts();
        @(negedge clk);
        reset = 1'b1;

        // default overlapping 1011
        send_seq(16'b1011011, 16'b0001001, 7);
        idle(1'b1);

        // non-overlap 111, seven ones
        cfg(8'h07, 4'd3, 1'b0);
        send_seq(16'b1111111, 16'b0010010, 7);

        // A5 across a 3-cycle valid gap
        cfg(8'hA5, 4'd8, 1'b1);
        send_seq(16'b1010, 16'b0000, 4);
        idle(1'b0); idle(1'b0); idle(1'b0);
        send_seq(16'b0101, 16'b0001, 4);

        // reconfig mid-pattern loses partial match; high pattern bits ignored
        cfg(8'hFB, 4'd4, 1'b1);
        send_seq(16'b101, 16'b000, 3);
        cfg(8'hFB, 4'd4, 1'b1);
        send_seq(16'b1, 16'b0, 1);
        send_seq(16'b1011, 16'b0001, 4);

        // saturation on the 2-bit counter, then clear beats a match
        idle(1'b1);
        cfg(8'h03, 4'd2, 1'b1);
        send_seq(16'b111111, 16'b011111, 6);
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0);

        // async reset clears outputs and restores the 1011 default
        async_reset();
        send_seq(16'b10, 16'b00, 2);
        async_reset();
        send_seq(16'b11011, 16'b00001, 5);

        // length 0 disables; length 12 clamps to 8
        cfg(8'h0B, 4'd0, 1'b1);
        send_seq(16'b10111011, 16'b0, 8);
        cfg(8'hA5, 4'd12, 1'b1);
        send_seq(16'hA5A5, 16'h0101, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_seq_detector.md
# prog_seq_detector

Parametrised Mealy serial-pattern detector, successor to the fixed 4-bit detector. It watches a 1-bit stream qualified by `in_valid` and raises `out` combinationally in the cycle the last bit of a run-time programmable pattern arrives. It sits between the serial front end and the event logic. It adds programmable pattern and length, selectable overlap or non-overlap mode, and a saturating match counter. Reset configuration reproduces the legacy overlapping "1011" detector.

## Interface
- `MAX_LEN`, default 8: maximum pattern length in bits (2..16).
- `CNT_W`, default 8: width of the match counter.
- `LEN_W` (localparam) = $clog2(MAX_LEN+1): width of `cfg_len`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; `reset`=0 clears all state immediately.
- `in`  in  1  serial data bit.
- `in_valid`  in  1  `in` is sampled only when 1.
- `cfg_we`  in  1  load configuration on this edge.
- `cfg_pattern`  in  MAX_LEN  pattern. Bit [len-1] is the first bit received; bit [0] is the last.
- `cfg_len`  in  LEN_W  pattern length. 0 disables detection; values above MAX_LEN are clamped to MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- `clr_count`  in  1  synchronous clear of `match_count`.
- `out`  out  1  Mealy match pulse, combinational.
- `out_r`  out  1  `out` registered; one cycle later.
- `match_count`  out  CNT_W  number of matches, saturating.
- `count_sat`  out  1  1 when `match_count` equals all ones.

## Operation
- State registers:
  - `hist[MAX_LEN-1:0]`: shift register of received bits; the newest bit is `hist[0]`.
  - `fill`: number of valid history bits, saturating at MAX_LEN.
  - `pat_r`, `len_r`, `ovl_r`: configuration registers.
  - `match_count` and `out_r`.
- Match rule, with len = `len_r`:
  - `out` = `in_valid` & !`cfg_we` & (len≠0) & (`fill` ≥ len−1) & ({`hist`,`in`}[len-1:0] == `pat_r`[len-1:0]).
  - `out` depends only on current state and current `in`, with no register in the path.
- On a valid bit, `hist` shifts left with `in` entering at bit 0.
- `fill` updates on a valid bit as follows:
  - If `out`=1 and `ovl_r`=0, `fill` becomes 0. History bits of the consumed match cannot start the next match.
  - Otherwise `fill` becomes min(`fill`+1, MAX_LEN).
- `in_valid`=0: `hist`, `fill` and the counter hold, and `out`=0.
- `cfg_we`=1 has priority over streaming:
  - It loads `pat_r`, clamped `len_r` and `ovl_r`, and sets `fill` to 0.
  - The `in` bit in that cycle is discarded, and `out`=0.
  - `match_count` is not affected.
- A configuration change takes effect from the next valid bit. A partial match in progress is lost.
- Counter:
  - On `out`=1, `match_count` increments, holding at 2^CNT_W−1.
  - `clr_count`=1 sets it to 0. When `clr_count` and `out` occur in the same cycle, clear wins and the result is 0.
- `count_sat` is decoded from the `match_count` register.
- Bits of `cfg_pattern` at or above `len_r` are ignored.

## Timing
- Reset (`reset`=0, asynchronous) sets:
  - `hist`=0, `fill`=0, `match_count`=0, `out_r`=0, `count_sat`=0.
  - `pat_r`=…0001011, `len_r`=4, `ovl_r`=1.
- `out` has 0-cycle latency: it asserts in the same cycle as the final pattern bit, before the clock edge.
- `out_r` follows `out` by one cycle. `match_count` reflects a match after that same edge.
- The first possible match for length L is the L-th valid bit after reset or after `cfg_we`.
- Deasserting reset mid-stream: detection restarts with `fill`=0, and no stale history bits participate.
- Gaps in `in_valid` are transparent. The pattern is matched across gaps of any length.
- Combinational path: `in`/`in_valid` → comparator → `out`. Downstream logic must register it or use `out_r`.

## Test plan
- Reset defaults, stream 1,0,1,1,0,1,1 (valid every cycle) → `out`=1 on bits 4 and 7 (overlap), `match_count`=2.
- `cfg_overlap`=0, len 3, pattern 3'b111, stream of seven 1s → `out` on bits 3 and 6 only, `match_count`=2.
- len 8, pattern 8'hA5, 8'hA5 sent MSB-first with `in_valid` dropped for 3 cycles after bit 4 → single `out` pulse on the 8th valid bit; `out`=0 during the gaps.
- `cfg_we` asserted after 3 bits of "1011", then the remainder sent → no match. Resend the full "1011" → match. `match_count` is preserved across `cfg_we`.
- CNT_W=2 build, 5 matches → `match_count`=3 with `count_sat`=1. `clr_count` coincident with a match → 0.
- `reset` pulled low asynchronously mid-pattern (between edges) → outputs clear immediately. `cfg_len`=0 load → `out` never asserts. `cfg_len`=12 with MAX_LEN=8 → behaves as len 8.
